// File: rtl/axi_r_stream_tap.sv
// rtl/axi_r_stream_tap.sv - AXI R-channel passthrough that captures each beat and re-emits it as a DATA/META word pair
module axi_r_stream_tap #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 32,
  parameter int USER_WIDTH = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  output logic                  valid,
  output logic                  in_progress,
  output logic [DATA_WIDTH-1:0] data,
  input  logic [ID_WIDTH-1:0]   AXIS_rid,
  input  logic [DATA_WIDTH-1:0] AXIS_rdata,
  input  logic [1:0]            AXIS_rresp,
  input  logic                  AXIS_rlast,
  input  logic [USER_WIDTH-1:0] AXIS_ruser,
  input  logic                  AXIS_rvalid,
  output logic                  AXIS_rready,
  output logic [ID_WIDTH-1:0]   AXIM_rid,
  output logic [DATA_WIDTH-1:0] AXIM_rdata,
  output logic [1:0]            AXIM_rresp,
  output logic                  AXIM_rlast,
  output logic [USER_WIDTH-1:0] AXIM_ruser,
  output logic                  AXIM_rvalid,
  input  logic                  AXIM_rready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + ID_WIDTH + 2 + 1 + 8;

  typedef enum logic {PH_DATA, PH_META} phase_t;

  phase_t                r_phase;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [7:0]            r_beat_cnt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [EW-1:0]         w_head;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [ID_WIDTH-1:0]   w_head_id;
  logic [1:0]            w_head_resp;
  logic                  w_head_last;
  logic [7:0]            w_head_cnt;
  logic [DATA_WIDTH-1:0] w_meta;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  assign AXIM_rid    = AXIS_rid;
  assign AXIM_rdata  = AXIS_rdata;
  assign AXIM_rresp  = AXIS_rresp;
  assign AXIM_rlast  = AXIS_rlast;
  assign AXIM_ruser  = AXIS_ruser;
  // During reset the channel stays live; the capture FIFO is simply bypassed.
  assign AXIM_rvalid = AXIS_rvalid & (reset | ~w_full);
  assign AXIS_rready = AXIM_rready & (reset | ~w_full);

  assign w_push = AXIS_rvalid & AXIS_rready & ~reset;
  assign w_pop  = (r_phase == PH_META) & ready & ~reset;

  assign w_head = r_mem[r_rptr];
  assign {w_head_data, w_head_id, w_head_resp, w_head_last, w_head_cnt} = w_head;

  always_comb begin
    w_meta = '0;
    w_meta[ID_WIDTH-1:0]          = w_head_id;
    w_meta[ID_WIDTH+1:ID_WIDTH]   = w_head_resp;
    w_meta[ID_WIDTH+2]            = w_head_last;
    w_meta[ID_WIDTH+10:ID_WIDTH+3] = w_head_cnt;
  end

  always_comb begin
    valid = 1'b0;
    data  = '0;
    if (r_phase == PH_META) begin
      valid = 1'b1;
      data  = w_meta;
    end else if (!w_empty) begin
      valid = 1'b1;
      data  = w_head_data;
    end
  end

  assign in_progress = (r_phase == PH_META);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {AXIS_rdata, AXIS_rid, AXIS_rresp, AXIS_rlast, r_beat_cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_beat_cnt <= 8'd0;
      r_phase    <= PH_DATA;
    end else begin
      if (w_push) begin
        r_wptr     <= r_wptr + 1'b1;
        r_beat_cnt <= AXIS_rlast ? 8'd0 : r_beat_cnt + 8'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // The head entry is only released once its META word is taken.
      case (r_phase)
        PH_DATA: if (valid && ready) r_phase <= PH_META;
        PH_META: if (ready) r_phase <= PH_DATA;
        default: r_phase <= PH_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_r_stream_tap.sv
// tb/tb_axi_r_stream_tap.sv - directed scoreboard bench for axi_r_stream_tap
module tb_axi_r_stream_tap;
  localparam int DW    = 128;
  localparam int IW    = 32;
  localparam int UW    = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic          valid;
  logic          in_progress;
  logic [DW-1:0] data;
  logic [IW-1:0] AXIS_rid;
  logic [DW-1:0] AXIS_rdata;
  logic [1:0]    AXIS_rresp;
  logic          AXIS_rlast;
  logic [UW-1:0] AXIS_ruser;
  logic          AXIS_rvalid;
  logic          AXIS_rready;
  logic [IW-1:0] AXIM_rid;
  logic [DW-1:0] AXIM_rdata;
  logic [1:0]    AXIM_rresp;
  logic          AXIM_rlast;
  logic [UW-1:0] AXIM_ruser;
  logic          AXIM_rvalid;
  logic          AXIM_rready;

  axi_r_stream_tap #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .valid(valid),
    .in_progress(in_progress), .data(data),
    .AXIS_rid(AXIS_rid), .AXIS_rdata(AXIS_rdata), .AXIS_rresp(AXIS_rresp),
    .AXIS_rlast(AXIS_rlast), .AXIS_ruser(AXIS_ruser), .AXIS_rvalid(AXIS_rvalid),
    .AXIS_rready(AXIS_rready),
    .AXIM_rid(AXIM_rid), .AXIM_rdata(AXIM_rdata), .AXIM_rresp(AXIM_rresp),
    .AXIM_rlast(AXIM_rlast), .AXIM_ruser(AXIM_ruser), .AXIM_rvalid(AXIM_rvalid),
    .AXIM_rready(AXIM_rready)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            n_ip  = 0;
  logic [DW-1:0] exp_q[$];
  int            m_count;
  logic          m_meta;
  logic [7:0]    m_cnt;
  logic          m_clean;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_meta(input logic [IW-1:0] id, input logic [1:0] resp,
                                            input logic last, input logic [7:0] cnt);
    logic [DW-1:0] w;
    w = '0;
    w[31:0]  = id;
    w[33:32] = resp;
    w[34]    = last;
    w[42:35] = cnt;
    return w;
  endfunction

  task automatic beat(input logic [IW-1:0] id, input logic [DW-1:0] d,
                      input logic [1:0] resp, input logic last);
    AXIS_rvalid = 1'b1;
    AXIS_rid    = id;
    AXIS_rdata  = d;
    AXIS_rresp  = resp;
    AXIS_rlast  = last;
    AXIS_ruser  = {$urandom, $urandom};
  endtask

  // One clock: check against the model, then advance the model across the edge.
  task automatic cycle();
    logic          exp_full;
    logic          exp_valid;
    logic          acc;
    logic          hs;
    logic [DW-1:0] tmp;
    #1;
    exp_full = !reset && (m_count == DEPTH);
    check("axim_rvalid", AXIM_rvalid, AXIS_rvalid & ~exp_full);
    check("axis_rready", AXIS_rready, AXIM_rready & ~exp_full);
    check("axim_rdata", AXIM_rdata, AXIS_rdata);
    check("axim_rid", AXIM_rid, AXIS_rid);
    check("axim_rresp", AXIM_rresp, AXIS_rresp);
    check("axim_rlast", AXIM_rlast, AXIS_rlast);
    check("axim_ruser", AXIM_ruser, AXIS_ruser);
    exp_valid = m_meta || (m_count != 0);
    check("valid", valid, exp_valid);
    check("in_progress", in_progress, m_meta);
    if (in_progress === 1'b1) n_ip++;
    if (exp_valid && exp_q.size() != 0) check("data", data, exp_q[0]);
    else if (m_clean) check("data_idle", data, '0);
    acc = AXIS_rvalid && AXIM_rready && !exp_full && !reset;
    hs  = exp_valid && ready && !reset;
    @(posedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      m_count = 0;
      m_meta  = 1'b0;
      m_cnt   = 8'd0;
      m_clean = 1'b1;
    end else begin
      if (hs && exp_q.size() != 0) begin
        tmp = exp_q.pop_front();
        if (m_meta) begin
          m_count--;
          m_meta = 1'b0;
        end else begin
          m_meta = 1'b1;
        end
      end
      if (acc) begin
        exp_q.push_back(AXIS_rdata);
        exp_q.push_back(mk_meta(AXIS_rid, AXIS_rresp, AXIS_rlast, m_cnt));
        m_count++;
        m_cnt   = AXIS_rlast ? 8'd0 : m_cnt + 8'd1;
        m_clean = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    ready = 1'b1;
    while (exp_q.size() != 0 && i < 100) begin
      cycle();
      i++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    ready       = 1'b0;
    AXIS_rvalid = 1'b0;
    AXIS_rid    = '0;
    AXIS_rdata  = '0;
    AXIS_rresp  = 2'b00;
    AXIS_rlast  = 1'b0;
    AXIS_ruser  = '0;
    AXIM_rready = 1'b1;
    @(posedge clk);
    #1;
    m_count = 0; m_meta = 1'b0; m_cnt = 8'd0; m_clean = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();

    // Single beat, sink ready
    ready = 1'b1;
    beat(32'h5, {16{8'hA5}}, 2'b00, 1'b1);
    cycle();
    AXIS_rvalid = 1'b0;
    n_ip = 0;
    drain("single");
    check("single_ip_cycles", n_ip, 1);
    cycle();

    // 4-beat burst with sink stalled, then drained
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(32'h10 + i, {$urandom, $urandom, $urandom, $urandom}, 2'b00, i == 3);
      cycle();
    end
    AXIS_rvalid = 1'b0;
    cycle();
    cycle();
    n_ip = 0;
    drain("burst");
    check("burst_ip_cycles", n_ip, 4);

    // Fill to full, offer a 9th beat, drain one pair, 9th goes in, 10th stalls
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(32'h20 + i, {$urandom, $urandom, $urandom, $urandom}, 2'b01, 1'b0);
      cycle();
    end
    beat(32'h28, {$urandom, $urandom, $urandom, $urandom}, 2'b00, 1'b0);
    cycle();
    ready = 1'b1;
    cycle();
    cycle();
    ready = 1'b0;
    cycle();
    beat(32'h29, {$urandom, $urandom, $urandom, $urandom}, 2'b00, 1'b1);
    cycle();
    cycle();
    AXIS_rvalid = 1'b0;
    drain("full");

    // META held under backpressure
    ready = 1'b0;
    beat(32'h33, {$urandom, $urandom, $urandom, $urandom}, 2'b11, 1'b1);
    cycle();
    AXIS_rvalid = 1'b0;
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    n_ip = 0;
    repeat (5) cycle();
    check("meta_hold_ip", n_ip, 5);
    drain("hold");

    // Reset in the middle of a pair with 3 entries queued
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(32'h40 + i, {$urandom, $urandom, $urandom, $urandom}, 2'b00, 1'b0);
      cycle();
    end
    AXIS_rvalid = 1'b0;
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    cycle();
    reset = 1'b1;
    beat(32'h77, {$urandom, $urandom, $urandom, $urandom}, 2'b01, 1'b0);
    cycle();
    AXIM_rready = 1'b0;
    cycle();
    reset       = 1'b0;
    AXIS_rvalid = 1'b0;
    AXIM_rready = 1'b1;
    ready       = 1'b1;
    n_ip = 0;
    repeat (4) cycle();
    check("post_reset_ip", n_ip, 0);

    // Error response with all-ones id; beat count restarts after reset
    beat(32'hFFFF_FFFF, {$urandom, $urandom, $urandom, $urandom}, 2'b10, 1'b1);
    cycle();
    AXIS_rvalid = 1'b0;
    drain("slverr");
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
